// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [31:0] MMIO_ADDR         = 32'hFFFF_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The read register only updates on a read access, so it holds its value otherwise.
module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Write on enabled store; capture the addressed word on enabled load.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready request, fixed wait states, one-cycle response strobe.
// Optional feature: define DMEM_MMIO_EN to add a memory-mapped output register at MMIO_ADDR.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam logic [32:0] RamBytes = 33'(64'd4 << DEPTH_LOG2);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_err_q, use_ram_q;
  logic [31:0] rsp_rdata_q;
  logic        accept, enter_resp;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, off;
  logic        is_mmio, in_range, misaligned, err;
  logic        ram_en;
  logic [31:0] ram_rdata, mmio_rd;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign accept    = req_ready && req_valid;

  // Next-state and wait counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so decode the live request then.
  always_comb begin
    cur_we     = req_ready ? req_we    : we_q;
    cur_addr   = req_ready ? req_addr  : addr_q;
    cur_wdata  = req_ready ? req_wdata : wdata_q;
    off        = cur_addr - BASE_ADDR;
    in_range   = (cur_addr >= BASE_ADDR) && ({1'b0, off} < RamBytes);
    misaligned = (cur_addr[1:0] != 2'b00);
`ifdef DMEM_MMIO_EN
    is_mmio    = (cur_addr == MMIO_ADDR);
`else
    is_mmio    = 1'b0;
`endif
    err        = misaligned || (!is_mmio && !in_range);
    // Reset on the entry edge drops the access entirely.
    ram_en     = enter_resp && !reset && !err && !is_mmio;
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (cur_we),
    .addr (off[DEPTH_LOG2+1:2]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q;

  // MMIO register updates on a store entering RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_q <= '0;
    end else if (enter_resp && is_mmio && cur_we && !err) begin
      mmio_q <= cur_wdata;
    end
  end

  assign mmio_out = mmio_q;
  assign mmio_rd  = mmio_q;
`else
  assign mmio_rd  = '0;
`endif

  // State, request latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      use_ram_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err_q   <= err;
        use_ram_q   <= ram_en && !cur_we;
        rsp_rdata_q <= (is_mmio && !cur_we && !err) ? mmio_rd : '0;
      end
    end
  end

  // Load data comes from the RAM read register, which holds until the next RAM load.
  assign rsp_rdata = use_ram_q ? ram_rdata : rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: one DUT with 2 wait states, one with 0 wait states.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t q0[$];

  logic        req_valid = 0, req_we = 0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid0 = 0, req_we0 = 0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out, mmio_out0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.WAIT_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_out (mmio_out)
`endif
  );

  data_memory_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid0),
    .req_ready(req_ready0),
    .req_we   (req_we0),
    .req_addr (req_addr0),
    .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0),
    .rsp_err  (rsp_err0)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_out (mmio_out0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the expected response whenever a DUT strobes rsp_valid.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rdata", rsp_rdata, e.rdata);
        chk("err", 32'(rsp_err), 32'(e.err));
        chk("latency", cyc - e.acc, 32'd3);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rsp_valid0) begin
      if (q0.size() == 0) chk("unexpected_rsp0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rdata0", rsp_rdata0, e.rdata);
        chk("err0", 32'(rsp_err0), 32'(e.err));
        chk("latency0", cyc - e.acc, 32'd1);
      end
    end
  end

  task automatic issue(input bit d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit push, input logic [31:0] er, input logic ee);
    int n;
    exp_t e;
    @(negedge clk);
    if (d) begin
      req_valid0 = 1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
    end else begin
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    end
    n = 0;
    while (!(d ? req_ready0 : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    e = '{rdata: er, err: ee, acc: cyc};
    if (push) begin
      if (d) q0.push_back(e);
      else q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    req_valid0 = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size() + q0.size(), 32'd0);
    #1;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready0", 32'(req_ready0), 32'd1);
    chk("rst_rdata0", rsp_rdata0, 32'd0);
`ifdef DMEM_MMIO_EN
    chk("rst_mmio", mmio_out, 32'd0);
`endif

    // Basic store/load.
    issue(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 1, 32'h0, 0);
    issue(0, 0, 32'h1001_0004, 32'h0, 1, 32'hDEAD_BEEF, 0);
    // Misaligned store leaves word 0 untouched.
    issue(0, 1, 32'h1001_0000, 32'h0BAD_F00D, 1, 32'h0, 0);
    issue(0, 1, 32'h1001_0002, 32'hFFFF_FFFF, 1, 32'h0, 1);
    issue(0, 0, 32'h1001_0000, 32'h0, 1, 32'h0BAD_F00D, 0);
    // Range boundaries.
    issue(0, 0, 32'h1000_FFFC, 32'h0, 1, 32'h0, 1);
    issue(0, 0, 32'h1001_1000, 32'h0, 1, 32'h0, 1);
    issue(0, 1, 32'h1001_0FFC, 32'h5555_AAAA, 1, 32'h0, 0);
    issue(0, 0, 32'h1001_0FFC, 32'h0, 1, 32'h5555_AAAA, 0);
    issue(0, 0, 32'h1001_0004, 32'h0, 1, 32'hDEAD_BEEF, 0);
    drain();

`ifdef DMEM_MMIO_EN
    issue(0, 1, 32'hFFFF_0000, 32'h0000_00A5, 1, 32'h0, 0);
    drain();
    chk("mmio_out", mmio_out, 32'h0000_00A5);
    issue(0, 0, 32'hFFFF_0000, 32'h0, 1, 32'h0000_00A5, 0);
`else
    issue(0, 1, 32'hFFFF_0000, 32'h0000_00A5, 1, 32'h0, 1);
`endif
    drain();

    // Reset on the edge that would enter RESP drops the store.
    issue(0, 1, 32'h1001_0008, 32'h1111_2222, 1, 32'h0, 0);
    drain();
    issue(0, 1, 32'h1001_0008, 32'h1234_5678, 0, 32'h0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    issue(0, 0, 32'h1001_0008, 32'h0, 1, 32'h1111_2222, 0);
    drain();

    // Zero wait states with req_valid held high.
    issue(1, 1, 32'h1001_0000, 32'hCAFE_0001, 1, 32'h0, 0);
    issue(1, 1, 32'h1001_0004, 32'hCAFE_0002, 1, 32'h0, 0);
    drain();
    req_valid0 = 1;
    req_we0 = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("zw_ready", 32'(req_ready0), 32'(i % 2 == 0));
      if (req_ready0 && k < 4) begin
        case (k)
          0: begin req_addr0 = 32'h1001_0000; q0.push_back('{32'hCAFE_0001, 1'b0, cyc}); end
          1: begin req_addr0 = 32'h1001_0004; q0.push_back('{32'hCAFE_0002, 1'b0, cyc}); end
          2: begin req_addr0 = 32'h1001_0000; q0.push_back('{32'hCAFE_0001, 1'b0, cyc}); end
          default: begin req_addr0 = 32'h1001_0001; q0.push_back('{32'h0, 1'b1, cyc}); end
        endcase
        k++;
      end
    end
    req_valid0 = 0;
    chk("zw_accepts", 32'(k), 32'd4);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
